// File: rtl/node_sequencer_pkg.sv
// Shared codes for the TIS-100 node sequencer: register-block commands, opcodes, source selectors,
// FSM states and the ACC saturation helper.
package node_sequencer_pkg;

  typedef enum logic [1:0] {
    RegNop   = 2'd0,
    RegSwp   = 2'd1,
    RegSav   = 2'd2,
    RegWrite = 2'd3
  } reg_instr_e;

  // Codes 14 and 15 are unassigned and execute as NOP.
  typedef enum logic [3:0] {
    OpNop    = 4'd0,
    OpMovAcc = 4'd1,
    OpMovOut = 4'd2,
    OpSwp    = 4'd3,
    OpSav    = 4'd4,
    OpAdd    = 4'd5,
    OpSub    = 4'd6,
    OpNeg    = 4'd7,
    OpJmp    = 4'd8,
    OpJez    = 4'd9,
    OpJnz    = 4'd10,
    OpJgz    = 4'd11,
    OpJlz    = 4'd12,
    OpJro    = 4'd13
  } op_e;

  // Bit 10 is shared by the selector and the immediate, so immediates are 0..1023.
  typedef enum logic [1:0] {
    SrcImm = 2'd0,
    SrcAcc = 2'd1,
    SrcNil = 2'd2,
    SrcIn  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StExec    = 2'd1,
    StWaitIn  = 2'd2,
    StWaitOut = 2'd3
  } state_e;

  function automatic logic signed [10:0] sat11(input logic signed [11:0] x, input int max_mag);
    int v;
    v = int'(x);
    if (v > max_mag) v = max_mag;
    else if (v < -max_mag) v = -max_mag;
    return 11'(v);
  endfunction

endpackage

// File: rtl/node_alu.sv
// Combinational ACC arithmetic: 12-bit signed intermediate clamped to +/-SAT_MAX, plus ACC sign flags.
module node_alu
  import node_sequencer_pkg::*;
#(
  parameter int SAT_MAX = 999
) (
  input  logic [3:0]         i_op,
  input  logic signed [10:0] i_acc,
  input  logic signed [10:0] i_src,
  output logic signed [10:0] o_result,
  output logic               o_zero,
  output logic               o_neg
);

  logic signed [11:0] w_acc_x;
  logic signed [11:0] w_src_x;
  logic signed [11:0] w_sum;

  assign w_acc_x = {i_acc[10], i_acc};
  assign w_src_x = {i_src[10], i_src};

  always_comb begin
    w_sum = w_acc_x;
    case (i_op)
      OpMovAcc: w_sum = w_src_x;
      OpAdd:    w_sum = w_acc_x + w_src_x;
      OpSub:    w_sum = w_acc_x - w_src_x;
      OpNeg:    w_sum = 12'sd0 - w_acc_x;
      default:  w_sum = w_acc_x;
    endcase
  end

  assign o_result = sat11(w_sum, SAT_MAX);
  assign o_zero   = (i_acc == 11'sd0);
  assign o_neg    = i_acc[10];

endmodule

// File: rtl/node_sequencer.sv
// Fetch/decode/execute controller for one TIS-100 node; drives the sibling ACC/BAK register block
// and performs blocking IN/OUT port handshakes.
module node_sequencer
  import node_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 4,
  parameter int          SAT_MAX = 999
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic [PC_W:0]      i_prog_len,
  output logic [PC_W-1:0]    o_prog_addr,
  input  logic [15:0]        i_prog_data,
  input  logic signed [10:0] i_acc,
  output logic [1:0]         o_reg_instr,
  output logic signed [10:0] o_reg_val,
  output logic               o_reg_clk_en,
  input  logic signed [10:0] i_in_data,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic signed [10:0] o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  state_e             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [15:0]        r_ir;
  reg_instr_e         r_reg_instr;
  logic signed [10:0] r_reg_val;
  logic               r_reg_clk_en;
  logic signed [10:0] r_out_data;
  logic               r_out_valid;

  logic [15:0]        w_ir;
  logic [3:0]         w_op;
  logic [1:0]         w_src;
  logic               w_uses_src;
  logic               w_need_in;
  logic               w_go;
  logic signed [10:0] w_src_val;
  logic signed [10:0] w_alu;
  logic               w_zero;
  logic               w_neg;
  logic               w_taken;
  reg_instr_e         w_reg_op;
  logic [PC_W:0]      w_len;
  logic [PC_W:0]      w_last_full;
  logic [PC_W-1:0]    w_pc_next;
  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_exec_pc;
  int                 w_jro;

  // ROM data is only valid in EXEC; later states replay the latched word.
  assign w_ir  = (r_state == StExec) ? i_prog_data : r_ir;
  assign w_op  = w_ir[15:12];
  assign w_src = w_ir[11:10];

  assign w_uses_src = (w_op == OpMovAcc) || (w_op == OpMovOut) || (w_op == OpAdd) ||
                      (w_op == OpSub) || (w_op == OpJro);
  assign w_need_in  = w_uses_src && (w_src == SrcIn);
  assign w_go       = ((r_state == StExec) && !(w_need_in && !i_in_valid)) ||
                      ((r_state == StWaitIn) && i_in_valid);

  always_comb begin
    w_src_val = 11'sd0;
    case (w_src)
      SrcImm:  w_src_val = $signed(w_ir[10:0]);
      SrcAcc:  w_src_val = i_acc;
      SrcNil:  w_src_val = 11'sd0;
      default: w_src_val = i_in_data;
    endcase
  end

  node_alu #(
    .SAT_MAX(SAT_MAX)
  ) u_alu (
    .i_op    (w_op),
    .i_acc   (i_acc),
    .i_src   (w_src_val),
    .o_result(w_alu),
    .o_zero  (w_zero),
    .o_neg   (w_neg)
  );

  assign w_len       = (i_prog_len == '0) ? {{PC_W{1'b0}}, 1'b1} : i_prog_len;
  assign w_last_full = w_len - 1'b1;
  assign w_pc_next   = ({1'b0, r_pc} >= w_last_full) ? '0 : r_pc + 1'b1;
  assign w_target    = ({1'b0, w_ir[PC_W-1:0]} < w_len) ? w_ir[PC_W-1:0] : '0;

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OpJmp:   w_taken = 1'b1;
      OpJez:   w_taken = w_zero;
      OpJnz:   w_taken = !w_zero;
      OpJgz:   w_taken = !w_zero && !w_neg;
      OpJlz:   w_taken = w_neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_jro     = int'(r_pc) + int'(w_src_val);
    w_exec_pc = w_taken ? w_target : w_pc_next;
    if (w_op == OpJro) begin
      if (w_jro < 0) w_exec_pc = '0;
      else if (w_jro > int'(w_last_full)) w_exec_pc = w_last_full[PC_W-1:0];
      else w_exec_pc = w_jro[PC_W-1:0];
    end
  end

  always_comb begin
    w_reg_op = RegNop;
    case (w_op)
      OpMovAcc, OpAdd, OpSub, OpNeg: w_reg_op = RegWrite;
      OpSwp:                         w_reg_op = RegSwp;
      OpSav:                         w_reg_op = RegSav;
      default:                       w_reg_op = RegNop;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StFetch;
      r_pc         <= '0;
      r_ir         <= '0;
      r_reg_instr  <= RegNop;
      r_reg_val    <= '0;
      r_reg_clk_en <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_reg_clk_en <= 1'b0;
      r_reg_instr  <= RegNop;
      case (r_state)
        StFetch: if (i_run) r_state <= StExec;
        StExec, StWaitIn: begin
          if (r_state == StExec) r_ir <= i_prog_data;
          if (w_go) begin
            if (w_reg_op != RegNop) begin
              r_reg_clk_en <= 1'b1;
              r_reg_instr  <= w_reg_op;
              if (w_reg_op == RegWrite) r_reg_val <= w_alu;
            end
            if (w_op == OpMovOut) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_src_val;
              r_state     <= StWaitOut;
            end else begin
              r_pc    <= w_exec_pc;
              r_state <= StFetch;
            end
          end else begin
            r_state <= StWaitIn;
          end
        end
        StWaitOut: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_next;
            r_state     <= StFetch;
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

  assign o_prog_addr  = r_pc;
  assign o_reg_instr  = r_reg_instr;
  assign o_reg_val    = r_reg_val;
  assign o_reg_clk_en = r_reg_clk_en;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_in_ready   = (r_state == StWaitIn) || ((r_state == StExec) && w_need_in);

endmodule
